wb_queue: RTL and testbench

- Write-back queue that drives the register file's single write port (write_enable, rt, write_data).
- Producers such as the ALU and memory stage push (register index, data) requests through a valid/ready handshake.
- Requests are buffered in a small FIFO and retired in order, at most one per cycle, as a one-cycle write strobe.
- A per-register pending mask lets the decode/read side detect read-after-write hazards on entries not yet written.

---
 rtl/wb_queue_pkg.sv | 17 +
 rtl/wb_queue_fifo.sv | 66 ++++++
 rtl/wb_queue.sv | 87 ++++++++
 tb/tb_wb_queue.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_queue_pkg.sv
// Shared types and defaults for the write-back queue (package wb_pkg).
package wb_pkg;

  localparam int COUNT_DEF = 2;
  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 4;

  typedef struct packed {
    logic [COUNT_DEF-1:0] addr;
    logic [DW_DEF-1:0]    data;
  } wb_req_t;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/wb_queue_fifo.sv
// Synchronous FIFO of write requests. Every entry's address and liveness is
// exported so the parent can build the pending-write mask.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               push,
  input  wb_req_t                            push_req,
  input  logic                               pop,
  output wb_req_t                            head,
  output logic                               full,
  output logic                               empty,
  output logic [occ_width(DEPTH)-1:0]        occupancy,
  output logic [DEPTH-1:0]                   ent_valid,
  output logic [DEPTH-1:0][COUNT_DEF-1:0]    ent_addr
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = occ_width(DEPTH);

  wb_req_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [OW-1:0]   occ;
  logic            do_push;
  logic            do_pop;

  assign full      = (occ == OW'(DEPTH));
  assign empty     = (occ == OW'(0));
  assign occupancy = occ;
  assign head      = mem[rd_ptr];
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_req;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // An entry is live when its distance from the read pointer is below occupancy.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = ({1'b0, AW'(AW'(i) - rd_ptr)} < occ);
      ent_addr[i]  = mem[i].addr;
    end
  end

endmodule

// File: rtl/wb_queue.sv
// Write-back queue driving the register-file write port. Defining
// WB_QUEUE_BYPASS_EN lets a request into an empty, unheld queue skip the FIFO.
module wb_queue
  import wb_pkg::*;
#(
  parameter int count = COUNT_DEF,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [count-1:0]             req_addr,
  input  logic [DW-1:0]                req_data,
  input  logic                         hold,
  output logic                         wr_en,
  output logic [count-1:0]             wr_addr,
  output logic [DW-1:0]                wr_data,
  output logic [2**count-1:0]          pending,
  output logic [occ_width(DEPTH)-1:0]  occupancy
);

  wb_req_t                       req;
  wb_req_t                       head;
  logic                          full;
  logic                          empty;
  logic                          accept;
  logic                          pop;
  logic                          bypass;
  logic [DEPTH-1:0]              ent_valid;
  logic [DEPTH-1:0][count-1:0]   ent_addr;

  assign req.addr  = req_addr;
  assign req.data  = req_data;
  assign req_ready = !full;
  assign accept    = req_valid && !full;
  assign pop       = !hold && !empty;

`ifdef WB_QUEUE_BYPASS_EN
  assign bypass = accept && empty && !hold;
`else
  assign bypass = 1'b0;
`endif

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept && !bypass),
    .push_req  (req),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .occupancy (occupancy),
    .ent_valid (ent_valid),
    .ent_addr  (ent_addr)
  );

  // Output stage: one registered strobe per retired entry; address/data hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (pop) begin
      wr_en   <= 1'b1;
      wr_addr <= head.addr;
      wr_data <= head.data;
    end else if (bypass) begin
      wr_en   <= 1'b1;
      wr_addr <= req_addr;
      wr_data <= req_data;
    end else begin
      wr_en   <= 1'b0;
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pending[ent_addr[i]] = pending[ent_addr[i]] | ent_valid[i];
    end
    pending[wr_addr] = pending[wr_addr] | wr_en;
  end

endmodule

// File: tb/tb_wb_queue.sv
// Scoreboard bench for wb_queue: directed scenarios plus random traffic against
// a queue-level reference model.
module tb_wb_queue;

`ifdef WB_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int DEPTH = 4;

  typedef struct {
    logic [1:0] a;
    logic [7:0] d;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_addr = 2'd0;
  logic [7:0] req_data = 8'd0;
  logic       hold = 1'b0;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] pending;
  logic [2:0] occupancy;

  wb_queue dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .hold(hold), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .pending(pending), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_on  = 1'b0;
  bit   last_acc;
  ent_t mq[$];
  ent_t sb[$];
  bit   m_en = 1'b0;
  ent_t m_out;
  logic [7:0] rf [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Queue-level view of one clock edge using the inputs presented for it.
  task automatic model_edge();
    int   pre;
    ent_t r;
    pre      = mq.size();
    last_acc = req_valid && (pre < DEPTH);
    r.a      = req_addr;
    r.d      = req_data;
    m_en     = 1'b0;
    if (!hold && pre > 0) begin
      m_out = mq.pop_front();
      m_en  = 1'b1;
    end
    if (last_acc) begin
      sb.push_back(r);
      if (BYP && pre == 0 && !hold) begin
        m_out = r;
        m_en  = 1'b1;
      end else begin
        mq.push_back(r);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [1:0] a, input logic [7:0] d, input bit h);
    req_valid = v;
    req_addr  = a;
    req_data  = d;
    hold      = h;
    tick();
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_pending", pending, 0);
    check("rst_ready", req_ready, 1);
    mq.delete();
    sb.delete();
    m_en    = 1'b0;
    m_out.a = 2'd0;
    m_out.d = 8'd0;
    req_valid = 1'b0;
    hold      = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  // Monitor: retire strobes against the scoreboard and compare visible state to the model.
  always @(negedge clk) begin
    if (mon_on) begin
      logic [3:0] mp;
      ent_t       e;
      mp = 4'd0;
      foreach (mq[i]) mp[mq[i].a] = 1'b1;
      if (m_en) mp[m_out.a] = 1'b1;
      check("wr_en", wr_en, m_en);
      check("occupancy", occupancy, mq.size());
      check("req_ready", req_ready, mq.size() < DEPTH);
      check("pending", pending, mp);
      if (wr_en) begin
        rf[wr_addr] = wr_data;
        if (sb.size() == 0) begin
          check("unexpected_strobe", {wr_addr, wr_data}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("strobe_addr_data", {wr_addr, wr_data}, {e.a, e.d});
        end
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("init_wr_en", wr_en, 0);
    check("init_occupancy", occupancy, 0);
    check("init_ready", req_ready, 1);
    check("init_pending", pending, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_on = 1'b1;

    // Single write: latency and pending window.
    drive(1'b1, 2'd2, 8'hA5, 1'b0);
    check("single_pending2", pending[2], 1);
    check("single_en_e1", wr_en, BYP ? 1 : 0);
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    check("single_en_e2", wr_en, BYP ? 0 : 1);
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    check("single_pending_clear", pending, 0);

    // Full backpressure: fill under hold, fifth request waits.
    for (int i = 0; i < 4; i++) drive(1'b1, 2'(i), 8'(8'h50 + i), 1'b1);
    check("full_occ", occupancy, 4);
    check("full_ready", req_ready, 0);
    for (int i = 0; i < 3; i++) drive(1'b1, 2'd1, 8'h3C, 1'b1);
    check("full_occ_still", occupancy, 4);
    hold = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (last_acc) req_valid = 1'b0;
      tick();
    end

    // Steady stream, one push per cycle.
    for (int i = 0; i < 20; i++) drive(1'b1, 2'($urandom_range(0, 3)), 8'($urandom), 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 2'd0, 8'h00, 1'b0);

    // Same-register ordering.
    drive(1'b1, 2'd3, 8'h11, 1'b0);
    drive(1'b1, 2'd3, 8'h22, 1'b0);
    drive(1'b1, 2'd0, 8'h33, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 2'd0, 8'h00, 1'b0);
    check("rf_r3", rf[3], 8'h22);
    check("rf_r0", rf[0], 8'h33);

    // Hold mid-drain.
    for (int i = 0; i < 3; i++) drive(1'b1, 2'(i + 1), 8'(8'hC0 + i), 1'b1);
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    drive(1'b0, 2'd0, 8'h00, 1'b1);
    drive(1'b0, 2'd0, 8'h00, 1'b1);
    check("hold_occ", occupancy, 2);
    for (int i = 0; i < 4; i++) drive(1'b0, 2'd0, 8'h00, 1'b0);

    // Random traffic; producer keeps an unaccepted request stable.
    last_acc = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!req_valid || last_acc) begin
        req_valid = ($urandom_range(0, 2) != 0);
        req_addr  = 2'($urandom_range(0, 3));
        req_data  = 8'($urandom);
      end
      hold = ($urandom_range(0, 3) == 0);
      tick();
    end
    for (int i = 0; i < 8; i++) drive(1'b0, 2'd0, 8'h00, 1'b0);
    check("drain_sb_empty", sb.size(), 0);

    // Reset mid-stream.
    for (int i = 0; i < 3; i++) drive(1'b1, 2'(i), 8'(8'h70 + i), 1'b1);
    pulse_reset();
    for (int i = 0; i < 4; i++) drive(1'b0, 2'd0, 8'h00, 1'b0);

    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
